// File: rtl/matmul_seq_ctrl.sv
// Host-side sequencer for the MxM systolic matmul array: buffers A/B, clears and feeds the
// array in skewed order, and collects C. Optional WAIT/COLLECT watchdog: MATMUL_SEQ_TIMEOUT_EN.
module matmul_seq_ctrl #(
    parameter int M       = 3,
    parameter int AW      = $clog2(M * M),
    parameter int TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          rstb,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data,
    output logic          arr_rst,
    output logic          arr_vld_in,
    output logic [7:0]    arr_a,
    output logic [7:0]    arr_b,
    output logic          arr_rdy_out,
    input  logic [15:0]   arr_c,
    input  logic          arr_vld_out
);
    localparam int              MM     = M * M;
    localparam int              KW     = (M > 1) ? $clog2(M) : 1;
    localparam logic [AW:0]     MM_W   = (AW + 1)'(MM);
    localparam logic [KW-1:0]   LAST_K = KW'(M - 1);
    localparam logic [AW-1:0]   LAST_C = AW'(MM - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLR     = 3'd1,
        S_FEED    = 3'd2,
        S_WAIT    = 3'd3,
        S_COLLECT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t        state_r;
    logic          busy_r;
    logic          done_r;
    logic          arr_rst_r;
    logic          arr_vld_in_r;
    logic          arr_rdy_out_r;
    logic [7:0]    arr_a_r;
    logic [7:0]    arr_b_r;
    logic [15:0]   rd_data_r;
    logic [KW-1:0] k_r;
    logic [KW-1:0] i_r;
    logic [AW-1:0] cnt_r;

    logic [KW-1:0] nk_s;
    logic [KW-1:0] ni_s;
    logic [AW-1:0] a_idx_s;
    logic [AW-1:0] b_idx_s;
    logic          feed_last_s;
    logic          wr_ok_s;
    logic          rd_ok_s;
    logic          accept_s;
    logic          last_word_s;

    logic [7:0]    a_mem_r [MM];
    logic [7:0]    b_mem_r [MM];
    logic [15:0]   c_mem_r [MM];

`ifdef MATMUL_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_r;
    logic          err_r;
    logic          tmo_hit_s;

    assign tmo_hit_s = (tmo_r == TW'(TIMEOUT - 1));
    assign err       = err_r;
`else
    // TIMEOUT stays in the parameter list so both builds share one interface.
    assign err = 1'b0 & (TIMEOUT < 0);
`endif

    assign feed_last_s = (k_r == LAST_K) && (i_r == LAST_K);
    assign wr_ok_s     = wr_en && (state_r == S_IDLE) && ({1'b0, wr_addr} < MM_W);
    assign rd_ok_s     = ({1'b0, rd_addr} < MM_W);
    assign accept_s    = arr_vld_out && arr_rdy_out_r &&
                         ((state_r == S_WAIT) || (state_r == S_COLLECT));
    assign last_word_s = (cnt_r == LAST_C);

    // Next feed position (k outer, i inner); outside FEED it primes position (0,0).
    always_comb begin
        nk_s = {KW{1'b0}};
        ni_s = {KW{1'b0}};
        if (state_r == S_FEED) begin
            if (i_r == LAST_K) begin
                ni_s = {KW{1'b0}};
                nk_s = k_r + KW'(1);
            end else begin
                ni_s = i_r + KW'(1);
                nk_s = k_r;
            end
        end else begin
            ni_s = {KW{1'b0}};
            nk_s = {KW{1'b0}};
        end
        a_idx_s = AW'(int'(ni_s) * M + int'(nk_s));
        b_idx_s = AW'(int'(nk_s) * M + int'(ni_s));
    end

    // Operand and result storage; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (wr_ok_s && !wr_sel) a_mem_r[wr_addr] <= wr_data;
        if (wr_ok_s && wr_sel)  b_mem_r[wr_addr] <= wr_data;
        if (accept_s)           c_mem_r[cnt_r]   <= arr_c;
    end

    // Sequencer FSM with registered array-control and host status outputs.
    always_ff @(posedge CLK or negedge rstb) begin
        if (!rstb) begin
            state_r       <= S_IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            rd_data_r     <= 16'h0000;
            arr_rst_r     <= 1'b1;
            arr_vld_in_r  <= 1'b1;
            arr_a_r       <= 8'h00;
            arr_b_r       <= 8'h00;
            arr_rdy_out_r <= 1'b0;
            k_r           <= {KW{1'b0}};
            i_r           <= {KW{1'b0}};
            cnt_r         <= {AW{1'b0}};
`ifdef MATMUL_SEQ_TIMEOUT_EN
            tmo_r         <= {TW{1'b0}};
            err_r         <= 1'b0;
`endif
        end else begin
            rd_data_r <= rd_ok_s ? c_mem_r[rd_addr] : 16'h0000;
            done_r    <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    arr_rst_r <= 1'b0;
                    if (start) begin
                        state_r   <= S_CLR;
                        busy_r    <= 1'b1;
                        arr_rst_r <= 1'b1;
`ifdef MATMUL_SEQ_TIMEOUT_EN
                        err_r     <= 1'b0;
`endif
                    end
                end
                S_CLR: begin
                    state_r      <= S_FEED;
                    arr_rst_r    <= 1'b0;
                    arr_vld_in_r <= 1'b0;
                    arr_a_r      <= a_mem_r[a_idx_s];
                    arr_b_r      <= b_mem_r[b_idx_s];
                    k_r          <= nk_s;
                    i_r          <= ni_s;
                    cnt_r        <= {AW{1'b0}};
                end
                S_FEED: begin
                    if (feed_last_s) begin
                        state_r       <= S_WAIT;
                        arr_vld_in_r  <= 1'b1;
                        arr_a_r       <= 8'h00;
                        arr_b_r       <= 8'h00;
                        arr_rdy_out_r <= 1'b1;
`ifdef MATMUL_SEQ_TIMEOUT_EN
                        tmo_r         <= {TW{1'b0}};
`endif
                    end else begin
                        arr_a_r <= a_mem_r[a_idx_s];
                        arr_b_r <= b_mem_r[b_idx_s];
                        k_r     <= nk_s;
                        i_r     <= ni_s;
                    end
                end
                S_WAIT, S_COLLECT: begin
                    if (accept_s) begin
                        state_r <= S_COLLECT;
                        cnt_r   <= cnt_r + AW'(1);
`ifdef MATMUL_SEQ_TIMEOUT_EN
                        tmo_r   <= {TW{1'b0}};
`endif
                        if (last_word_s) begin
                            state_r       <= S_DONE;
                            busy_r        <= 1'b0;
                            done_r        <= 1'b1;
                            arr_rdy_out_r <= 1'b0;
                        end
                    end
`ifdef MATMUL_SEQ_TIMEOUT_EN
                    else if (tmo_hit_s) begin
                        state_r       <= S_DONE;
                        busy_r        <= 1'b0;
                        done_r        <= 1'b1;
                        arr_rdy_out_r <= 1'b0;
                        err_r         <= 1'b1;
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                    end
`endif
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r       <= S_IDLE;
                    busy_r        <= 1'b0;
                    arr_vld_in_r  <= 1'b1;
                    arr_rdy_out_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign rd_data     = rd_data_r;
    assign arr_rst     = arr_rst_r;
    assign arr_vld_in  = arr_vld_in_r;
    assign arr_a       = arr_a_r;
    assign arr_b       = arr_b_r;
    assign arr_rdy_out = arr_rdy_out_r;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl with a behavioural array that rebuilds A and B from the
// fed operand stream and returns their product.
module tb_matmul_seq_ctrl;
    localparam int M   = 3;
    localparam int MM  = 9;
    localparam int AW  = 4;
    localparam int TMO = 16;

    logic        CLK = 1'b0;
    logic        rstb = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        start = 1'b0;
    logic [3:0]  rd_addr = 4'd0;
    logic [15:0] arr_c = 16'd0;
    logic        arr_vld_out = 1'b0;
    logic        busy, done, err, arr_rst, arr_vld_in, arr_rdy_out;
    logic [15:0] rd_data;
    logic [7:0]  arr_a, arr_b;

    matmul_seq_ctrl #(.M(M), .AW(AW), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .rstb(rstb), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done), .err(err),
        .rd_addr(rd_addr), .rd_data(rd_data), .arr_rst(arr_rst), .arr_vld_in(arr_vld_in),
        .arr_a(arr_a), .arr_b(arr_b), .arr_rdy_out(arr_rdy_out), .arr_c(arr_c),
        .arr_vld_out(arr_vld_out)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int neg = 0;
    logic signed [7:0] fa [MM];
    logic signed [7:0] fb [MM];
    logic [15:0] mc [MM];
    int nfeed, ndone, done_neg, wait_neg, last_word_neg, first_feed_neg, start_neg;

    int ident [MM]   = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int fo_a [MM]    = '{1, 1, 0, 0, 1, 0, 0, 1, 1};
    int fo_b [MM]    = '{1, 0, 0, 0, 2, 0, 2, 0, 1};
    int fo_seq_a [MM] = '{1, 0, 0, 1, 1, 1, 0, 0, 1};
    int fo_seq_b [MM] = '{1, 0, 0, 0, 2, 0, 2, 0, 1};
    int fo_c [MM]    = '{1, 2, 0, 0, 2, 0, 2, 2, 1};

    task automatic tick();
        @(negedge CLK);
        neg = neg + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic sel, input int addr, input int data);
        wr_en = 1'b1;
        wr_sel = sel;
        wr_addr = 4'(addr);
        wr_data = 8'(data);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load(input int a [MM], input int b [MM]);
        for (int i = 0; i < MM; i++) wr(1'b0, i, a[i]);
        for (int i = 0; i < MM; i++) wr(1'b1, i, b[i]);
    endtask

    task automatic chk_c(input string pfx, input int exp [MM]);
        for (int i = 0; i < MM; i++) begin
            rd_addr = 4'(i);
            tick();
            chk($sformatf("%s_c%0d", pfx, i), rd_data, exp[i]);
        end
    endtask

    task automatic do_run(input int gap_after, input int gap_len, input bit lock,
                          input int abort_t, input bit no_data, input int max_cyc);
        int widx, gap, s;
        bit computed, ended;
        nfeed = 0; ndone = 0; done_neg = -1; wait_neg = -1; last_word_neg = -1;
        first_feed_neg = -1; widx = 0; gap = 0; computed = 1'b0; ended = 1'b0;
        start = 1'b1;
        start_neg = neg;
        tick();
        start = 1'b0;
        chk("clr_arr_rst", arr_rst, 1);
        chk("clr_busy", busy, 1);
        chk("clr_err_clear", err, 0);
        for (int c = 0; c < max_cyc && !ended; c++) begin
            arr_vld_out = 1'b0;
            wr_en = 1'b0;
            start = 1'b0;
            if (arr_vld_in == 1'b0) begin
                if (nfeed == 0) first_feed_neg = neg;
                if (nfeed < MM) begin
                    fa[nfeed] = arr_a;
                    fb[nfeed] = arr_b;
                end
                nfeed = nfeed + 1;
                if (lock && nfeed == 4) begin
                    start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd5;
                    arr_vld_out = 1'b1; arr_c = 16'h1234;
                end
            end
            if (arr_rdy_out && wait_neg < 0) wait_neg = neg;
            if (arr_rdy_out && !no_data) begin
                if (!computed) begin
                    // Array model: A[r][k] = fa[k*M+r], B[k][c] = fb[k*M+c].
                    for (int r = 0; r < M; r++)
                        for (int cc = 0; cc < M; cc++) begin
                            s = 0;
                            for (int k = 0; k < M; k++)
                                s = s + int'(fa[k*M+r]) * int'(fb[k*M+cc]);
                            mc[r*M+cc] = s[15:0];
                        end
                    computed = 1'b1;
                end
                if (widx == gap_after && gap < gap_len) gap = gap + 1;
                else if (widx < MM) begin
                    arr_vld_out = 1'b1;
                    arr_c = mc[widx];
                    if (widx == MM - 1) last_word_neg = neg;
                    widx = widx + 1;
                end
            end
            if (widx == MM && neg > last_word_neg && neg <= last_word_neg + 2) begin
                arr_vld_out = 1'b1;
                arr_c = 16'hBEEF;
            end
            if (done) begin
                ndone = ndone + 1;
                if (done_neg < 0) done_neg = neg;
                chk("done_busy_low", busy, 0);
            end
            if (done_neg >= 0 && neg >= done_neg + 3) ended = 1'b1;
            if (abort_t >= 0 && nfeed == abort_t + 1) begin
                rstb = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_arr_rst", arr_rst, 1);
                chk("abort_vld_in", arr_vld_in, 1);
                tick();
                rstb = 1'b1;
                for (int j = 0; j < 20; j++) begin
                    tick();
                    if (done) ndone = ndone + 1;
                end
                chk("abort_no_done", ndone, 0);
                ended = 1'b1;
            end
            if (!ended) tick();
        end
        arr_vld_out = 1'b0;
        if (!no_data) chk("run_ended", ended, 1);
    endtask

    initial begin
        #2 rstb = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_arr_rst", arr_rst, 1);
        chk("rst_vld_in", arr_vld_in, 1);
        chk("rst_arr_a", arr_a, 0);
        chk("rst_arr_b", arr_b, 0);
        chk("rst_rdy_out", arr_rdy_out, 0);
        rstb = 1'b1;
        tick();
        chk("idle_arr_rst", arr_rst, 0);

        load(ident, ident);
        do_run(99, 0, 1'b0, -1, 1'b0, 200);
        chk("id_feed_latency", first_feed_neg - start_neg, 2);
        chk("id_nfeed", nfeed, MM);
        chk("id_ndone", ndone, 1);
        chk("id_done_after_last", done_neg - last_word_neg, 1);
        chk_c("id", ident);

        load(fo_a, fo_b);
        do_run(99, 0, 1'b0, -1, 1'b0, 200);
        for (int i = 0; i < MM; i++) begin
            chk($sformatf("fo_a%0d", i), 32'(fa[i]), fo_seq_a[i]);
            chk($sformatf("fo_b%0d", i), 32'(fb[i]), fo_seq_b[i]);
        end
        chk("fo_nfeed", nfeed, MM);
        chk_c("fo", fo_c);

        do_run(5, 2, 1'b0, -1, 1'b0, 200);
        chk("stall_ndone", ndone, 1);
        chk("stall_done_after_last", done_neg - last_word_neg, 1);
        chk("stall_err", err, 0);
        chk_c("stall", fo_c);

        do_run(99, 0, 1'b1, -1, 1'b0, 200);
        chk("lock_ndone", ndone, 1);
        chk_c("lock", fo_c);
        do_run(99, 0, 1'b0, -1, 1'b0, 200);
        chk("relock_ndone", ndone, 1);
        chk_c("relock", fo_c);

        do_run(99, 0, 1'b0, 4, 1'b0, 200);
        tick();
        do_run(99, 0, 1'b0, -1, 1'b0, 200);
        chk("post_abort_ndone", ndone, 1);
        chk_c("post_abort", fo_c);

        rd_addr = 4'd9;
        tick();
        chk("rd_oor_9", rd_data, 0);
        rd_addr = 4'd15;
        tick();
        chk("rd_oor_15", rd_data, 0);

`ifdef MATMUL_SEQ_TIMEOUT_EN
        do_run(99, 0, 1'b0, -1, 1'b1, 60);
        chk("tmo_ndone", ndone, 1);
        chk("tmo_done_delay", done_neg - wait_neg, TMO);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        do_run(99, 0, 1'b0, -1, 1'b0, 200);
        chk("tmo_recover_ndone", ndone, 1);
        chk_c("tmo_recover", fo_c);
`else
        do_run(99, 0, 1'b0, -1, 1'b1, 80);
        chk("wait_busy", busy, 1);
        chk("wait_rdy_out", arr_rdy_out, 1);
        chk("wait_ndone", ndone, 0);
        chk("wait_err", err, 0);
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        tick();
        chk("wait_reset_busy", busy, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

endmodule
